// File: rtl/mpm_pkg.sv
// Shared types and register map for the multi-project mux.
// The optional strap boot is enabled by defining MPM_STRAP_BOOT_EN.
package mpm_pkg;

   // Sequencer states; encoding is visible in STATUS.STATE
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAssert = 2'd1,
      StHold   = 2'd2,
      StRun    = 2'd3
   } mpm_state_e;

   // Word index (adr[3:2]) of each register in the 16-byte window
   localparam logic [1:0] RegCtrl   = 2'd0;
   localparam logic [1:0] RegStatus = 2'd1;

   localparam int unsigned SelW          = 3;
   localparam int unsigned CtrlEnBit     = 8;
   localparam int unsigned StatErrBit    = 9;
   localparam int unsigned StatBusyBit   = 8;
   localparam int unsigned StatStateLsb  = 4;

   function automatic logic [31:0] pack_ctrl(input logic en, input logic [SelW-1:0] sel);
      logic [31:0] r;
      r = '0;
      r[CtrlEnBit] = en;
      r[SelW-1:0]  = sel;
      return r;
   endfunction

   function automatic logic [31:0] pack_status(input logic err, input mpm_state_e st,
                                               input logic [SelW-1:0] active);
      logic [31:0] r;
      r = '0;
      r[StatErrBit]                 = err;
      r[StatBusyBit]                = (st == StAssert) || (st == StHold);
      r[StatStateLsb +: 2]          = st;
      r[SelW-1:0]                   = active;
      return r;
   endfunction

endpackage

// File: rtl/mpm_wb_regs.sv
// Wishbone slave for the multi-project mux: window decode, single-cycle ack,
// CTRL/ERR storage and STATUS readback. With MPM_STRAP_BOOT_EN defined, the
// first cycle after reset loads CTRL from the pad strap.
module mpm_wb_regs
   import mpm_pkg::*;
#(
   parameter int unsigned NumSlots = 4,
   parameter logic [31:0] BaseAddr = 32'h3000_0000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
`ifdef MPM_STRAP_BOOT_EN
   input  logic [SelW-1:0]  strap_i,
`endif
   input  mpm_state_e       state_i,
   input  logic [SelW-1:0]  active_i,
   output logic             ctrl_en_o,
   output logic [SelW-1:0]  ctrl_sel_o
);

   logic            ack_q;
   logic [31:0]     rdat_q;
   logic            en_q;
   logic [SelW-1:0] sel_q;
   logic            err_q;

   logic            hit;
   logic            take;
   logic [1:0]      word;
   logic            ctrl_wr;
   logic            sel_bad;
   logic [31:0]     rdata;

   assign hit     = wbs_adr_i[31:4] == BaseAddr[31:4];
   // ~ack_q keeps a held strobe from acking on consecutive cycles
   assign take    = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
   assign word    = wbs_adr_i[3:2];
   assign ctrl_wr = take & wbs_we_i & (word == RegCtrl) & (wbs_sel_i[0] | wbs_sel_i[1]);
   assign sel_bad = wbs_sel_i[0] & (32'(wbs_dat_i[SelW-1:0]) >= NumSlots);

   // Read mux over the register window
   always_comb begin
      rdata = '0;
      case (word)
         RegCtrl:   rdata = pack_ctrl(en_q, sel_q);
         RegStatus: rdata = pack_status(err_q, state_i, active_i);
         default:   rdata = '0;
      endcase
   end

   // Ack and registered read data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_q  <= 1'b0;
         rdat_q <= '0;
      end else begin
         ack_q  <= take;
         rdat_q <= (take && !wbs_we_i) ? rdata : '0;
      end
   end

`ifdef MPM_STRAP_BOOT_EN
   logic boot_q;

   // One-cycle flag marking the first cycle after reset release
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) boot_q <= 1'b1;
      else         boot_q <= 1'b0;
   end
`endif

   // CTRL and ERR; an out-of-range SEL rejects the whole write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q  <= 1'b0;
         sel_q <= '0;
         err_q <= 1'b0;
`ifdef MPM_STRAP_BOOT_EN
      end else if (boot_q) begin
         if (32'(strap_i) < NumSlots) begin
            en_q  <= 1'b1;
            sel_q <= strap_i;
         end else begin
            err_q <= 1'b1;
         end
`endif
      end else if (ctrl_wr) begin
         if (sel_bad) begin
            err_q <= 1'b1;
         end else begin
            err_q <= 1'b0;
            if (wbs_sel_i[0]) sel_q <= wbs_dat_i[SelW-1:0];
            if (wbs_sel_i[1]) en_q  <= wbs_dat_i[CtrlEnBit];
         end
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = rdat_q;
   assign ctrl_en_o  = en_q;
   assign ctrl_sel_o = sel_q;

   logic unused_bits;
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_dat_i[7:3], wbs_sel_i[3:2]};

endmodule

// File: rtl/multi_project_mux.sv
// Multi-slot pad/LA/IRQ mux with reset sequencing. One slot owns the pads at
// a time; every switch passes through a tri-stated, reset-held gap.
// Optional strap boot from io_in[2:0]: define MPM_STRAP_BOOT_EN.
module multi_project_mux
   import mpm_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned IO_PADS   = 38,
   parameter int unsigned LA_BITS   = 64,
   parameter int unsigned RST_HOLD  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_ni,
   input  logic                           wbs_stb_i,
   input  logic                           wbs_cyc_i,
   input  logic                           wbs_we_i,
   input  logic [3:0]                     wbs_sel_i,
   input  logic [31:0]                    wbs_adr_i,
   input  logic [31:0]                    wbs_dat_i,
   output logic                           wbs_ack_o,
   output logic [31:0]                    wbs_dat_o,
   input  logic [IO_PADS-1:0]             io_in,
   output logic [IO_PADS-1:0]             io_out,
   output logic [IO_PADS-1:0]             io_oeb,
   output logic [LA_BITS-1:0]             la_data_out,
   output logic [2:0]                     user_irq,
   output logic [NUM_SLOTS*IO_PADS-1:0]   slot_io_in,
   input  logic [NUM_SLOTS*IO_PADS-1:0]   slot_io_out,
   input  logic [NUM_SLOTS*IO_PADS-1:0]   slot_io_oeb,
   input  logic [NUM_SLOTS*LA_BITS-1:0]   slot_la_out,
   input  logic [NUM_SLOTS*3-1:0]         slot_irq,
   output logic [NUM_SLOTS-1:0]           slot_rst_n,
   output logic [NUM_SLOTS-1:0]           slot_clk_en
);

   localparam int unsigned CntW = $clog2(RST_HOLD);
   localparam logic [CntW-1:0] CntLoad = CntW'(RST_HOLD - 1);

   mpm_state_e      state_q;
   logic [SelW-1:0] active_q;
   logic [CntW-1:0] cnt_q;
   logic            ctrl_en;
   logic [SelW-1:0] ctrl_sel;

   mpm_wb_regs #(
      .NumSlots (NUM_SLOTS),
      .BaseAddr (BASE_ADDR)
   ) u_regs (
      .clk_i      (wb_clk_i),
      .rst_ni     (wb_rst_ni),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
`ifdef MPM_STRAP_BOOT_EN
      .strap_i    (io_in[SelW-1:0]),
`endif
      .state_i    (state_q),
      .active_i   (active_q),
      .ctrl_en_o  (ctrl_en),
      .ctrl_sel_o (ctrl_sel)
   );

   // Reset sequencer; ACTIVE only changes in StAssert, so SEL != ACTIVE
   // identifies a pending slot change in every later state
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= StIdle;
         active_q <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ctrl_en) state_q <= StAssert;
            end
            StAssert: begin
               if (!ctrl_en) begin
                  state_q <= StIdle;
               end else begin
                  active_q <= ctrl_sel;
                  cnt_q    <= CntLoad;
                  state_q  <= StHold;
               end
            end
            StHold: begin
               if (!ctrl_en)                  state_q <= StIdle;
               else if (ctrl_sel != active_q) state_q <= StAssert;
               else if (cnt_q == '0)          state_q <= StRun;
               else                           cnt_q   <= cnt_q - 1'b1;
            end
            StRun: begin
               if (!ctrl_en)                  state_q <= StIdle;
               else if (ctrl_sel != active_q) state_q <= StAssert;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Slot control and pad mux, combinational from registered state/ACTIVE
   always_comb begin
      slot_rst_n  = '0;
      slot_clk_en = '0;
      slot_io_in  = '0;
      io_out      = '0;
      io_oeb      = '1;
      la_data_out = '0;
      user_irq    = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (active_q == SelW'(s)) begin
            if (state_q == StHold || state_q == StRun) begin
               slot_clk_en[s]                   = 1'b1;
               slot_io_in[s*IO_PADS +: IO_PADS] = io_in;
            end
            if (state_q == StRun) begin
               slot_rst_n[s] = 1'b1;
               io_out        = slot_io_out[s*IO_PADS +: IO_PADS];
               io_oeb        = slot_io_oeb[s*IO_PADS +: IO_PADS];
               la_data_out   = slot_la_out[s*LA_BITS +: LA_BITS];
               user_irq      = slot_irq[s*3 +: 3];
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_project_mux.sv
// Directed bench for multi_project_mux (default build, MPM_STRAP_BOOT_EN undefined).
module tb_multi_project_mux;

   localparam int unsigned NS   = 4;
   localparam int unsigned IOP  = 38;
   localparam int unsigned LAB  = 64;
   localparam int unsigned HOLD = 16;
   localparam logic [31:0] B    = 32'h3000_0000;
   localparam logic [IOP-1:0] IoInPat = 38'h2A_5A5A_A5A5;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  stb, cyc, we;
   logic [3:0]            sel;
   logic [31:0]           adr, dat;
   logic                  wbs_ack_o;
   logic [31:0]           wbs_dat_o;
   logic [IOP-1:0]        io_in, io_out, io_oeb;
   logic [LAB-1:0]        la_data_out;
   logic [2:0]            user_irq;
   logic [NS*IOP-1:0]     slot_io_in, slot_io_out, slot_io_oeb;
   logic [NS*LAB-1:0]     slot_la_out;
   logic [NS*3-1:0]       slot_irq;
   logic [NS-1:0]         slot_rst_n, slot_clk_en;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multi_project_mux #(
      .NUM_SLOTS (NS),
      .IO_PADS   (IOP),
      .LA_BITS   (LAB),
      .RST_HOLD  (HOLD),
      .BASE_ADDR (B)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wbs_stb_i   (stb),
      .wbs_cyc_i   (cyc),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_adr_i   (adr),
      .wbs_dat_i   (dat),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .io_in       (io_in),
      .io_out      (io_out),
      .io_oeb      (io_oeb),
      .la_data_out (la_data_out),
      .user_irq    (user_irq),
      .slot_io_in  (slot_io_in),
      .slot_io_out (slot_io_out),
      .slot_io_oeb (slot_io_oeb),
      .slot_la_out (slot_la_out),
      .slot_irq    (slot_irq),
      .slot_rst_n  (slot_rst_n),
      .slot_clk_en (slot_clk_en)
   );

   function automatic logic [IOP-1:0] pat_out(input int k);
      return {6'(k + 1), 32'hC0DE_0000 | 32'(k)};
   endfunction
   function automatic logic [IOP-1:0] pat_oeb(input int k);
      return {6'(k), 32'h0F0F_0000 | 32'(k << 4)};
   endfunction
   function automatic logic [LAB-1:0] pat_la(input int k);
      return {32'hDEAD_0000 | 32'(k), 32'h0000_BEE0 | 32'(k)};
   endfunction
   function automatic logic [2:0] pat_irq(input int k);
      return 3'(k + 1);
   endfunction
   function automatic logic [NS*IOP-1:0] exp_sio(input int k);
      logic [NS*IOP-1:0] r;
      r = '0;
      r[k*IOP +: IOP] = IoInPat;
      return r;
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One Wishbone access; waits at most 4 cycles for ack
   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic acked, output logic [31:0] rd);
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
      acked = 1'b0;
      rd    = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (wbs_ack_o) begin
            acked = 1'b1;
            rd    = wbs_dat_o;
            break;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        exp_ack;
      logic [31:0] exp_rd;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ea, input logic [31:0] er,
                      input string nm);
      vec_t v;
      v.w = w; v.a = a; v.d = d; v.s = s; v.exp_ack = ea; v.exp_rd = er; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic        ack;
      logic [31:0] rd;
      int          bad;
      int          acks;

      rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
      io_in = IoInPat;
      for (int k = 0; k < NS; k++) begin
         slot_io_out[k*IOP +: IOP] = pat_out(k);
         slot_io_oeb[k*IOP +: IOP] = pat_oeb(k);
         slot_la_out[k*LAB +: LAB] = pat_la(k);
         slot_irq[k*3 +: 3]        = pat_irq(k);
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_oeb", io_oeb, {IOP{1'b1}});
      check("rst_io_out", io_out, 0);
      check("rst_slot_rst_n", slot_rst_n, 0);
      check("rst_clk_en", slot_clk_en, 0);
      check("rst_la_irq", {la_data_out, user_irq}, 0);
      check("rst_ack", wbs_ack_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Register-level vectors, EN kept 0 throughout
      add(0, B + 32'h0, 32'h0,     4'hF, 1, 32'h000, "ctrl_reset");
      add(0, B + 32'h4, 32'h0,     4'hF, 1, 32'h000, "status_reset");
      add(0, B + 32'h8, 32'h0,     4'hF, 1, 32'h000, "rsvd_8");
      add(0, B + 32'hC, 32'h0,     4'hF, 1, 32'h000, "rsvd_c");
      add(1, B + 32'h0, 32'h007,   4'hF, 1, 32'h000, "wr_sel7");
      add(0, B + 32'h4, 32'h0,     4'hF, 1, 32'h200, "err_set");
      add(0, B + 32'h0, 32'h0,     4'hF, 1, 32'h000, "ctrl_kept");
      add(1, B + 32'h0, 32'h003,   4'hF, 1, 32'h000, "wr_sel3");
      add(0, B + 32'h4, 32'h0,     4'hF, 1, 32'h000, "err_clr");
      add(0, B + 32'h0, 32'h0,     4'hF, 1, 32'h003, "ctrl_sel3");
      add(1, B + 32'h0, 32'h001,   4'h2, 1, 32'h000, "wr_byte1_only");
      add(0, B + 32'h0, 32'h0,     4'hF, 1, 32'h003, "byte0_masked");
      add(1, B + 32'h0, 32'h106,   4'h1, 1, 32'h000, "wr_sel6_byte0");
      add(0, B + 32'h4, 32'h0,     4'hF, 1, 32'h200, "err_sel6");
      add(1, B + 32'h0, 32'h101,   4'h1, 1, 32'h000, "wr_sel1_byte0");
      add(0, B + 32'h0, 32'h0,     4'hF, 1, 32'h001, "byte1_masked");
      add(0, B + 32'h4, 32'h0,     4'hF, 1, 32'h000, "err_clr2");
      add(1, B + 32'h4, 32'hFFFF,  4'hF, 1, 32'h000, "wr_status_ro");
      add(0, B + 32'h0, 32'h0,     4'hF, 1, 32'h001, "ctrl_after_ro");
      add(0, B + 32'h10, 32'h0,    4'hF, 0, 32'h000, "outside_10");
      add(1, 32'h2000_0000, 32'h1, 4'hF, 0, 32'h000, "outside_base");
      add(1, B + 32'h0, 32'h000,   4'hF, 1, 32'h000, "wr_zero");
      add(0, B + 32'h0, 32'h0,     4'hF, 1, 32'h000, "ctrl_zero");

      foreach (vecs[i]) begin
         wb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, ack, rd);
         check({vecs[i].name, "_ack"}, ack, vecs[i].exp_ack);
         if (vecs[i].exp_ack && !vecs[i].w) check(vecs[i].name, rd, vecs[i].exp_rd);
      end
      check("idle_after_table", slot_clk_en, 0);

      // Boot slot 2: ack in cycle N, RUN at N+18
      wb_xfer(1, B, 32'h102, 4'hF, ack, rd);
      check("wr102_ack", ack, 1);
      wb_xfer(0, B + 32'h4, 32'h0, 4'hF, ack, rd);
      check("status_busy", rd, 32'h110);
      repeat (15) @(posedge clk);
      #1;
      check("hold_rst_n", slot_rst_n, 4'b0000);
      check("hold_clk_en", slot_clk_en, 4'b0100);
      check("hold_oeb", io_oeb, {IOP{1'b1}});
      check("hold_io_in", slot_io_in, exp_sio(2));
      @(posedge clk); #1;
      check("run2_rst_n", slot_rst_n, 4'b0100);
      check("run2_io_out", io_out, pat_out(2));
      check("run2_oeb", io_oeb, pat_oeb(2));
      check("run2_la", la_data_out, pat_la(2));
      check("run2_irq", user_irq, pat_irq(2));

      // Switch to slot 1 from RUN
      wb_xfer(1, B, 32'h101, 4'hF, ack, rd);
      check("wr101_ack", ack, 1);
      check("run_in_ack_cycle", io_out, pat_out(2));
      bad = 0;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         if (slot_rst_n != 4'b0000) bad++;
         if (k == 1) check("switch_tristate", io_oeb, {IOP{1'b1}});
      end
      check("switch_gap_rst", bad, 0);
      check("switch_hold_clk_en", slot_clk_en, 4'b0010);
      @(posedge clk); #1;
      check("run1_rst_n", slot_rst_n, 4'b0010);
      check("run1_io_out", io_out, pat_out(1));
      check("run1_io_in", slot_io_in, exp_sio(1));

      // Invalid SEL while running
      wb_xfer(1, B, 32'h107, 4'hF, ack, rd);
      wb_xfer(0, B + 32'h4, 32'h0, 4'hF, ack, rd);
      check("status_err_run", rd, 32'h231);
      wb_xfer(0, B, 32'h0, 4'hF, ack, rd);
      check("ctrl_unchanged", rd, 32'h101);
      check("still_run1", slot_rst_n, 4'b0010);
      wb_xfer(1, B, 32'h100, 4'hF, ack, rd);
      wb_xfer(0, B + 32'h4, 32'h0, 4'hF, ack, rd);
      check("err_clr_busy", rd, 32'h111);

      // Async reset mid-HOLD
      repeat (3) @(posedge clk);
      #1;
      check("hold_slot0", slot_clk_en, 4'b0001);
      rst_n = 1'b0;
      #1;
      check("arst_clk_en", slot_clk_en, 0);
      check("arst_rst_n", slot_rst_n, 0);
      check("arst_oeb", io_oeb, {IOP{1'b1}});
      check("arst_slot_io_in", slot_io_in, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      check("post_rst_idle", {slot_rst_n, slot_clk_en}, 0);
      wb_xfer(0, B + 32'h4, 32'h0, 4'hF, ack, rd);
      check("post_rst_status", rd, 32'h000);
      wb_xfer(0, B, 32'h0, 4'hF, ack, rd);
      check("post_rst_ctrl", rd, 32'h000);

      // Held strobe acks every other cycle
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = B + 32'h8; sel = 4'hF;
      acks = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (wbs_ack_o) acks++;
      end
      stb = 1'b0; cyc = 1'b0;
      check("held_stb_acks", acks, 2);

      // Run slot 3, then clear EN
      wb_xfer(1, B, 32'h103, 4'hF, ack, rd);
      repeat (20) @(posedge clk);
      #1;
      check("run3_rst_n", slot_rst_n, 4'b1000);
      check("run3_io_out", io_out, pat_out(3));
      wb_xfer(1, B, 32'h003, 4'hF, ack, rd);
      @(posedge clk); #1;
      check("en_clr_rst_n", slot_rst_n, 0);
      check("en_clr_clk_en", slot_clk_en, 0);
      check("en_clr_la", la_data_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_project_mux.md
# multi_project_mux

Multi-slot successor to the single-design top-level wrapper: hosts up to NUM_SLOTS user designs (CPU cores, peripherals) behind one set of Caravel pads and LA lines. Exactly one slot drives the pads at a time; all others are held in reset with clock disabled. The management SoC selects the slot through a Wishbone register. A reset-sequencing FSM guarantees a tri-stated, reset-held gap on every switch. The block sits directly inside user_project_wrapper, between the pads and the slot instances.

## Interface
Parameters:
- NUM_SLOTS, 4, number of hosted designs (2..8)
- IO_PADS, 38, pad count (matches MPRJ_IO_PADS)
- LA_BITS, 64, logic-analyzer output width
- RST_HOLD, 16, cycles of reset/tri-state gap on a switch (≥2)
- BASE_ADDR, 32'h3000_0000, Wishbone window base (16-byte window)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32  address, write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- io_in  in  IO_PADS  pad inputs
- io_out, io_oeb  out  IO_PADS  pad outputs / output-enable-bar
- la_data_out  out  LA_BITS  LA from active slot
- user_irq  out  3  IRQ from active slot
- slot_io_in  out  NUM_SLOTS*IO_PADS  per-slot pad inputs
- slot_io_out, slot_io_oeb  in  NUM_SLOTS*IO_PADS  per-slot pad drive
- slot_la_out  in  NUM_SLOTS*LA_BITS  per-slot LA
- slot_irq  in  NUM_SLOTS*3  per-slot IRQ
- slot_rst_n  out  NUM_SLOTS  per-slot reset, active-low
- slot_clk_en  out  NUM_SLOTS  per-slot clock enable

## Operation
- Registers (word offset): 0x0 CTRL {bit8 EN, bits[2:0] SEL}, R/W; 0x4 STATUS {bit9 ERR, bit8 BUSY, bits[5:4] STATE, bits[2:0] ACTIVE}, RO; 0x8/0xC read 0.
- Decode: adr[31:4]==BASE_ADDR[31:4]; outside window, no ack. Writes honour wbs_sel_i[0]/[1] only.
- Write of SEL ≥ NUM_SLOTS: CTRL unchanged, ERR set. ERR clears on next accepted CTRL write.
- FSM states: IDLE(0), ASSERT(1), HOLD(2), RUN(3).
- IDLE: all slot_rst_n=0, slot_clk_en=0. Pads: io_oeb all 1, io_out 0. la_data_out 0, user_irq 0. EN=1 → ASSERT.
- ASSERT: one cycle. Latches ACTIVE←SEL, loads counter with RST_HOLD-1 → HOLD.
- HOLD: pads still tri-stated; slot_clk_en[ACTIVE]=1 while rst_n is held low. Counter reaches 0 → RUN.
- RUN: slot_rst_n[ACTIVE]=1. io_out/io_oeb/la_data_out/user_irq mux from slot ACTIVE.
- RUN exits: CTRL write that changes SEL → ASSERT; CTRL write that clears EN → IDLE.
- CTRL write during ASSERT/HOLD: latched. Changed SEL restarts via ASSERT; EN=0 → IDLE.
- slot_io_in: io_in to ACTIVE slot only in HOLD/RUN; all other slots get 0.
- BUSY = state ∈ {ASSERT, HOLD}.

## Timing
- Reset: state IDLE, CTRL 0, ACTIVE 0, ERR 0, counter 0, wbs_ack_o 0, wbs_dat_o 0, all slot_rst_n 0, slot_clk_en 0, io_oeb all 1, io_out 0, la_data_out 0, user_irq 0. Applies even mid-RUN, immediately (async).
- Wishbone: ack asserted the cycle after stb&cyc sample a decoded address, held one cycle only. No back-to-back ack; a held strobe acks every other cycle. Read data is registered with the ack.
- CTRL write acked in cycle N: FSM sees the new value at N+1. From IDLE, RUN is entered at N+2+RST_HOLD.
- Pad/LA/IRQ mux is combinational from registered ACTIVE/state: zero added latency for slot-to-pad data.

## Configuration
- MPM_STRAP_BOOT_EN defined: on reset release, io_in[2:0] is sampled in the first cycle. If valid (<NUM_SLOTS), CTRL←{EN=1, SEL=strap} and the FSM auto-boots that slot. If invalid, stay IDLE with ERR=1.
- Undefined: boots IDLE with CTRL=0; only Wishbone can enable a slot.

## Structure
- Shared package mpm_pkg: state enum (IDLE/ASSERT/HOLD/RUN), register offsets, CTRL/STATUS bit positions.
- One sub-module, mpm_wb_regs: Wishbone decode, ack, CTRL/ERR storage, STATUS readback.
- FSM and pad mux stay in the top.

## Test plan
- Reset, RST_HOLD=16: all io_oeb=1, slot_rst_n=0000, STATUS reads 0x000.
- Write CTRL=0x102 → BUSY within 2 cycles; slot_rst_n=0100 exactly 18 cycles after ack; pads follow slot 2 drive.
- In RUN on slot 2, write CTRL=0x101 → pads tri-state the next cycle; slot 1 released 18 cycles later; slot 2 held in reset throughout.
- Write CTRL=0x107 with NUM_SLOTS=4 → CTRL unchanged, STATUS.ERR=1. Next write 0x100 clears ERR.
- Assert wb_rst_ni low mid-HOLD → all outputs at reset values the same cycle; after release, no slot runs until a CTRL write.
- Read offset 0x8 → 0 with ack. Access BASE_ADDR+0x10 → no ack within 4 cycles.
